// File: rtl/psum_drain.sv
// Accumulator-bank reader: snapshots all lanes on start, streams one quantized lane
// per valid/ready beat, then pulses acc_clear once so the bank can be zeroed.
module psum_drain #(
    parameter int SIZE       = 8,
    parameter int PSUM_WIDTH = 45,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 8,
    parameter int IDX_WIDTH  = $clog2(SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       relu_en,
    input  logic [SIZE*PSUM_WIDTH-1:0] psum_bus,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic [IDX_WIDTH-1:0]       out_index,
    output logic                       out_last,
    output logic                       acc_clear
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_CLEAR} state_t;

    localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX =
        {{(PSUM_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN =
        {{(PSUM_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SIZE-1);

    // Shift, optional ReLU and saturation, all at full accumulator width.
    function automatic logic [OUT_WIDTH-1:0] quantize(input logic [PSUM_WIDTH-1:0] p,
                                                      input logic relu);
        logic signed [PSUM_WIDTH-1:0] v;
        v = $signed(p) >>> SHIFT;
        if (relu && v[PSUM_WIDTH-1])
            v = '0;
        if (v > SAT_MAX)
            return OUT_MAX;
        else if (v < SAT_MIN)
            return OUT_MIN;
        else
            return v[OUT_WIDTH-1:0];
    endfunction

    state_t                r_state;
    logic [PSUM_WIDTH-1:0] r_shadow [SIZE];
    logic                  r_relu;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [OUT_WIDTH-1:0]  r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_busy;
    logic                  r_acc_clear;

    logic [IDX_WIDTH-1:0]  w_idx_next;
    logic [PSUM_WIDTH-1:0] w_lane0;

    assign w_idx_next = r_idx + 1'b1;
    assign w_lane0    = psum_bus[0 +: PSUM_WIDTH];

    // The output word is registered one lane ahead so nothing reaches the port
    // combinationally from psum_bus or start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            for (int unsigned i = 0; i < SIZE; i++)
                r_shadow[i] <= '0;
            r_relu      <= 1'b0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_acc_clear <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < SIZE; i++)
                            r_shadow[i] <= psum_bus[i*PSUM_WIDTH +: PSUM_WIDTH];
                        r_relu      <= relu_en;
                        r_idx       <= '0;
                        r_out_data  <= quantize(w_lane0, relu_en);
                        r_out_valid <= 1'b1;
                        r_out_last  <= (SIZE == 1);
                        r_busy      <= 1'b1;
                        r_state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_acc_clear <= 1'b1;
                            r_state     <= S_CLEAR;
                        end else begin
                            r_idx       <= w_idx_next;
                            r_out_data  <= quantize(r_shadow[w_idx_next], r_relu);
                            r_out_last  <= (w_idx_next == LAST_IDX);
                        end
                    end
                end
                S_CLEAR: begin
                    r_acc_clear <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_acc_clear <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_idx;
    assign out_last  = r_out_last;
    assign acc_clear = r_acc_clear;

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Reader side of the column accumulator bank. On a start pulse it captures all SIZE accumulated partial sums in one cycle.
- It then streams them out one lane per beat over a valid/ready interface. Each beat is quantized by arithmetic shift, optional ReLU and saturation.
- After the last beat it issues a one-cycle acc_clear pulse so the controller can zero the accumulators for the next tile.
- Sits between the accumulator bank and the output buffer / activation writeback path.

Parameters:
- SIZE, 8, number of accumulator columns (lanes).
- PSUM_WIDTH, 45, width of one accumulated partial sum, two's complement. Equals ((8*4)+4)+SIZE+1.
- OUT_WIDTH, 16, width of the quantized output word, two's complement.
- SHIFT, 8, arithmetic right-shift amount applied before saturation.
- IDX_WIDTH, $clog2(SIZE), width of the lane index (3 at default).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  capture request pulse; honoured only in IDLE.
- relu_en  input  1  ReLU enable; sampled together with psum_bus on an accepted start.
- psum_bus  input  SIZE*PSUM_WIDTH  flattened accumulator outputs; lane i at bits [i*PSUM_WIDTH +: PSUM_WIDTH].
- busy  output  1  high in STREAM and CLEAR.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  OUT_WIDTH  quantized lane value.
- out_index  output  IDX_WIDTH  lane number of the current beat.
- out_last  output  1  high with the beat for lane SIZE-1.
- acc_clear  output  1  one-cycle pulse after the final beat.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, out_valid, out_last, acc_clear = 0; out_data = 0; out_index = 0; shadow registers = 0; latched relu = 0.
- FSM states are IDLE, STREAM, CLEAR.
- IDLE:
  - On start=1 at edge T: all SIZE lanes of psum_bus go into the shadow registers, relu_en is latched, idx=0, next state STREAM.
  - From edge T onward: busy=1 and out_valid=1, with lane 0 presented.
- STREAM:
  - out_valid=1. out_data, out_index=idx and out_last=(idx==SIZE-1) come from registered state only; there is no combinational path from psum_bus or start.
  - Transfer happens when out_valid && out_ready at a clock edge.
  - On a transfer with idx<SIZE-1: idx increments.
  - On a transfer with idx==SIZE-1: next state CLEAR, out_valid drops.
  - With out_ready=0, out_data, out_index and out_last hold stable. No beat is skipped or duplicated.
- CLEAR: acc_clear=1 for exactly one cycle, busy=1, out_valid=0. Next state IDLE.
- Ignored inputs:
  - start outside IDLE has no effect.
  - psum_bus and relu_en changes after capture do not affect the stream.
- Latency: start at edge T with out_ready held high gives beats at edges T+1..T+SIZE and acc_clear high in cycle T+SIZE..T+SIZE+1. busy=0 and the block is back in IDLE after edge T+SIZE+1. A start there is accepted.
- Quantization, per lane:
  - v = signed(shadow) >>> SHIFT, an arithmetic shift, which floors (-1 >>> 8 = -1).
  - If latched relu and v<0, then v=0.
  - Saturate: v > 2^(OUT_WIDTH-1)-1 gives 0x7FFF; v < -2^(OUT_WIDTH-1) gives 0x8000 (values for OUT_WIDTH=16).
  - Internal arithmetic is at full PSUM_WIDTH with no intermediate truncation.
- Reset mid-stream: the stream is abandoned immediately, no acc_clear is emitted, and the block returns to IDLE.

Test Plan:
1. Lane i = i*256, relu_en=0, start pulse, out_ready=1 -> 8 beats with out_data 0..7 and out_index 0..7 on consecutive cycles; out_last only on index 7; one acc_clear cycle immediately after; busy low afterward.
2. Lane0 = -512, lane1 = -1: relu_en=0 -> 0xFFFE, 0xFFFF; rerun with relu_en=1 -> 0x0000, 0x0000.
3. Lane0 = 2^30, lane1 = -(2^30), lane2 = 32767*256 -> 0x7FFF, 0x8000, 0x7FFF (exact, no saturation needed on lane2).
4. Backpressure: out_ready low for 3 cycles during beat 2 and toggling randomly elsewhere -> data and index held stable while stalled; exactly 8 transfers in order; acc_clear only after the 8th.
5. Second start during STREAM, and psum_bus rewritten to all 0x1FFFFFFF after capture -> ignored; outputs equal the originally captured values; only one acc_clear.
6. rst asserted asynchronously after beat 3 -> out_valid and busy fall without a clock edge, no acc_clear; a fresh start after deassert streams 8 correct beats from index 0.
